// File: rtl/pfgen_stride.sv
// pfgen_stride: PC-indexed stride prefetch generator.
//
// Watches demand loads, trains a direct-mapped stride table and emits one
// prefetch op {delta, weight, laddr, sptbr} toward the prefetch engine. The op
// sits in a single output register until the engine takes it (valid=1, retry=0).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ld_valid/pc/laddr/sptbr  observed demand load (always accepted)
//   flush                 invalidate every table entry (wins over ld_valid)
//   pfgtopfe_op_valid     prefetch op valid
//   pfgtopfe_op_retry     engine busy; hold the current op
//   pfgtopfe_op_d/w/laddr/sptbr  op fields: stride, confidence, target, page base
//
// Optional build macro PFGEN_STATS_EN adds pfgen_issue_cnt (transfers) and
// pfgen_drop_cnt (issues lost to backpressure), both 16-bit saturating.
module pfgen_stride #(
    parameter int ENTRIES    = 16,
    parameter int TAG_W      = 8,
    parameter int PC_W       = 32,
    parameter int LADDR_W    = 39,
    parameter int SPTBR_W    = 38,
    parameter int DELTA_W    = 8,
    parameter int WEIGHT_W   = 4,
    parameter int LINE_SHIFT = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic [PC_W-1:0]     ld_pc,
    input  logic [LADDR_W-1:0]  ld_laddr,
    input  logic [SPTBR_W-1:0]  ld_sptbr,
    input  logic                flush,
    output logic                pfgtopfe_op_valid,
    input  logic                pfgtopfe_op_retry,
    output logic [DELTA_W-1:0]  pfgtopfe_op_d,
    output logic [WEIGHT_W-1:0] pfgtopfe_op_w,
    output logic [LADDR_W-1:0]  pfgtopfe_op_laddr,
    output logic [SPTBR_W-1:0]  pfgtopfe_op_sptbr
`ifdef PFGEN_STATS_EN
    ,
    output logic [15:0]         pfgen_issue_cnt,
    output logic [15:0]         pfgen_drop_cnt
`endif
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int LINE_W = LADDR_W - LINE_SHIFT;
    localparam logic [DELTA_W-1:0] DELTA_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

    // Stride table state
    logic [ENTRIES-1:0] tbl_valid_q, tbl_valid_d;
    logic [TAG_W-1:0]   tbl_tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tbl_tag_d    [ENTRIES];
    logic [LINE_W-1:0]  tbl_line_q   [ENTRIES];
    logic [LINE_W-1:0]  tbl_line_d   [ENTRIES];
    logic [DELTA_W-1:0] tbl_stride_q [ENTRIES];
    logic [DELTA_W-1:0] tbl_stride_d [ENTRIES];
    logic [1:0]         tbl_conf_q   [ENTRIES];
    logic [1:0]         tbl_conf_d   [ENTRIES];

    // Output op register
    logic                op_valid_q, op_valid_d;
    logic [DELTA_W-1:0]  op_d_q, op_d_d;
    logic [WEIGHT_W-1:0] op_w_q, op_w_d;
    logic [LADDR_W-1:0]  op_laddr_q, op_laddr_d;
    logic [SPTBR_W-1:0]  op_sptbr_q, op_sptbr_d;

    // Lookup / training datapath
    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [LINE_W-1:0]  line_s;
    logic               hit_s;
    logic [LINE_W-1:0]  delta_s;
    logic [DELTA_W-1:0] delta_tr_s;
    logic               in_range_s;
    logic               match_s;
    logic [DELTA_W-1:0] stride_new_s;
    logic [1:0]         conf_new_s;
    logic               issue_s;
    logic [LINE_W-1:0]  tgt_line_s;
    logic               load_s;
    logic               drop_s;
    logic               xfer_s;
    logic               pc_unused_s;

    assign idx_s  = ld_pc[IDX_W+1:2];
    assign tag_s  = ld_pc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign line_s = ld_laddr[LADDR_W-1:LINE_SHIFT];
    assign pc_unused_s = ^{ld_pc[PC_W-1:IDX_W+2+TAG_W], ld_pc[1:0], ld_laddr[LINE_SHIFT-1:0]};

    // Hit detection, stride/confidence training and issue decision
    always_comb begin
        hit_s      = tbl_valid_q[idx_s] && (tbl_tag_q[idx_s] == tag_s);
        delta_s    = line_s - tbl_line_q[idx_s];
        delta_tr_s = delta_s[DELTA_W-1:0];
        // The full-width delta fits if it equals the sign extension of its low
        // bits; the most negative code is excluded to keep the range symmetric.
        in_range_s = (delta_s == {{(LINE_W-DELTA_W){delta_tr_s[DELTA_W-1]}}, delta_tr_s})
                     && (delta_tr_s != DELTA_MIN);
        match_s    = in_range_s && (delta_tr_s != {DELTA_W{1'b0}})
                     && (delta_tr_s == tbl_stride_q[idx_s]);
        if (match_s) begin
            stride_new_s = tbl_stride_q[idx_s];
            conf_new_s   = (tbl_conf_q[idx_s] == 2'd3) ? 2'd3 : (tbl_conf_q[idx_s] + 2'd1);
        end else begin
            stride_new_s = (in_range_s && (delta_tr_s != {DELTA_W{1'b0}})) ? delta_tr_s
                                                                           : {DELTA_W{1'b0}};
            conf_new_s   = 2'd0;
        end
        issue_s    = ld_valid && !flush && hit_s && (conf_new_s >= 2'd2)
                     && (stride_new_s != {DELTA_W{1'b0}});
        tgt_line_s = line_s + {{(LINE_W-DELTA_W){stride_new_s[DELTA_W-1]}}, stride_new_s};
    end

    // Next table contents: flush clears everything, otherwise a load writes its entry
    always_comb begin
        tbl_valid_d  = tbl_valid_q;
        tbl_tag_d    = tbl_tag_q;
        tbl_line_d   = tbl_line_q;
        tbl_stride_d = tbl_stride_q;
        tbl_conf_d   = tbl_conf_q;
        if (flush) begin
            tbl_valid_d = {ENTRIES{1'b0}};
        end else if (ld_valid) begin
            tbl_valid_d[idx_s] = 1'b1;
            tbl_tag_d[idx_s]   = tag_s;
            tbl_line_d[idx_s]  = line_s;
            if (hit_s) begin
                tbl_stride_d[idx_s] = stride_new_s;
                tbl_conf_d[idx_s]   = conf_new_s;
            end else begin
                tbl_stride_d[idx_s] = {DELTA_W{1'b0}};
                tbl_conf_d[idx_s]   = 2'd0;
            end
        end else begin
            tbl_valid_d = tbl_valid_q;
        end
    end

    // Output register: reload when empty or draining this cycle, else hold
    always_comb begin
        load_s     = !op_valid_q || !pfgtopfe_op_retry;
        xfer_s     = op_valid_q && !pfgtopfe_op_retry;
        drop_s     = issue_s && !load_s;
        op_valid_d = op_valid_q;
        op_d_d     = op_d_q;
        op_w_d     = op_w_q;
        op_laddr_d = op_laddr_q;
        op_sptbr_d = op_sptbr_q;
        if (load_s) begin
            op_valid_d = issue_s;
            if (issue_s) begin
                op_d_d     = stride_new_s;
                op_w_d     = {{(WEIGHT_W-2){1'b0}}, conf_new_s};
                op_laddr_d = {tgt_line_s, {LINE_SHIFT{1'b0}}};
                op_sptbr_d = ld_sptbr;
            end else begin
                op_d_d = op_d_q;
            end
        end else begin
            op_valid_d = op_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_tag_q[i]    <= {TAG_W{1'b0}};
                tbl_line_q[i]   <= {LINE_W{1'b0}};
                tbl_stride_q[i] <= {DELTA_W{1'b0}};
                tbl_conf_q[i]   <= 2'd0;
            end
            op_valid_q <= 1'b0;
            op_d_q     <= {DELTA_W{1'b0}};
            op_w_q     <= {WEIGHT_W{1'b0}};
            op_laddr_q <= {LADDR_W{1'b0}};
            op_sptbr_q <= {SPTBR_W{1'b0}};
        end else begin
            tbl_valid_q  <= tbl_valid_d;
            tbl_tag_q    <= tbl_tag_d;
            tbl_line_q   <= tbl_line_d;
            tbl_stride_q <= tbl_stride_d;
            tbl_conf_q   <= tbl_conf_d;
            op_valid_q   <= op_valid_d;
            op_d_q       <= op_d_d;
            op_w_q       <= op_w_d;
            op_laddr_q   <= op_laddr_d;
            op_sptbr_q   <= op_sptbr_d;
        end
    end

    assign pfgtopfe_op_valid = op_valid_q;
    assign pfgtopfe_op_d     = op_d_q;
    assign pfgtopfe_op_w     = op_w_q;
    assign pfgtopfe_op_laddr = op_laddr_q;
    assign pfgtopfe_op_sptbr = op_sptbr_q;

`ifdef PFGEN_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating transfer and drop counters
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (xfer_s && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end else begin
            issue_cnt_d = issue_cnt_q;
        end
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign pfgen_issue_cnt = issue_cnt_q;
    assign pfgen_drop_cnt  = drop_cnt_q;
`else
    logic stats_unused_s;
    assign stats_unused_s = xfer_s ^ drop_s;
`endif

endmodule

// File: tb/tb_pfgen_stride.sv
module tb_pfgen_stride;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic [31:0] ld_pc;
    logic [38:0] ld_laddr;
    logic [37:0] ld_sptbr;
    logic        flush;
    logic        op_valid;
    logic        op_retry;
    logic [7:0]  op_d;
    logic [3:0]  op_w;
    logic [38:0] op_laddr;
    logic [37:0] op_sptbr;
`ifdef PFGEN_STATS_EN
    logic [15:0] issue_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pfgen_stride dut (
        .clk               (clk),
        .reset             (reset),
        .ld_valid          (ld_valid),
        .ld_pc             (ld_pc),
        .ld_laddr          (ld_laddr),
        .ld_sptbr          (ld_sptbr),
        .flush             (flush),
        .pfgtopfe_op_valid (op_valid),
        .pfgtopfe_op_retry (op_retry),
        .pfgtopfe_op_d     (op_d),
        .pfgtopfe_op_w     (op_w),
        .pfgtopfe_op_laddr (op_laddr),
        .pfgtopfe_op_sptbr (op_sptbr)
`ifdef PFGEN_STATS_EN
        ,
        .pfgen_issue_cnt   (issue_cnt),
        .pfgen_drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ldv;
        logic [31:0] pc;
        logic [38:0] la;
        logic [37:0] sp;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  ew;
        logic [38:0] ela;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic ldv, input logic [31:0] pc, input logic [38:0] la,
                       input logic [37:0] sp, input logic ev, input logic [7:0] ed,
                       input logic [3:0] ew, input logic [38:0] ela);
        vec_t v;
        v.ldv = ldv; v.pc = pc; v.la = la; v.sp = sp;
        v.ev = ev; v.ed = ed; v.ew = ew; v.ela = ela;
        vt.push_back(v);
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [38:0] la,
                         input logic [37:0] sp, input logic fl, input logic rt);
        ld_valid = v; ld_pc = pc; ld_laddr = la; ld_sptbr = sp; flush = fl; op_retry = rt;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_op(input string nm, input logic ev, input logic [7:0] ed,
                            input logic [3:0] ew, input logic [38:0] el, input logic [37:0] es);
        checks++;
        if (op_valid !== ev) begin
            errors++;
            $display("FAIL %s: valid=%0b expected %0b", nm, op_valid, ev);
        end else if (ev && (op_d !== ed || op_w !== ew || op_laddr !== el || op_sptbr !== es)) begin
            errors++;
            $display("FAIL %s: got d=%h w=%h laddr=%h sptbr=%h expected d=%h w=%h laddr=%h sptbr=%h",
                     nm, op_d, op_w, op_laddr, op_sptbr, ed, ew, el, es);
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({op_valid, op_d, op_w, op_laddr, op_sptbr} !== 90'd0) begin
            errors++;
            $display("FAIL %s: valid=%0b d=%h w=%h laddr=%h sptbr=%h expected all zero",
                     nm, op_valid, op_d, op_w, op_laddr, op_sptbr);
        end
    endtask

`ifdef PFGEN_STATS_EN
    task automatic check_drop(input string nm, input logic [15:0] exp);
        checks++;
        if (drop_cnt !== exp) begin
            errors++;
            $display("FAIL %s: drop_cnt=%0d expected %0d", nm, drop_cnt, exp);
        end
    endtask
`endif

    // Four loads with a +1 line stride from base; op with w=2 after the last.
    task automatic train4(input logic [31:0] pc, input logic [38:0] base, input string nm);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pc, base + 39'(i * 64), 38'h55, 1'b0, 1'b0);
        end
        check_op(nm, 1'b1, 8'h01, 4'd2, base + 39'h100, 38'h55);
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_pc = 32'd0; ld_laddr = 39'd0;
        ld_sptbr = 38'd0; flush = 1'b0; op_retry = 1'b0;
        #12;
        check_zero("reset_state");
        reset = 1'b0;

        // Positive stride, PC 0x400
        add(1'b1, 32'h400, 39'h1000, 38'h120, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h400, 39'h1040, 38'h121, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h400, 39'h1080, 38'h122, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h400, 39'h10C0, 38'h123, 1'b1, 8'h01, 4'd2, 39'h1100);
        add(1'b1, 32'h400, 39'h1100, 38'h124, 1'b1, 8'h01, 4'd3, 39'h1140);
        add(1'b0, 32'h0,   39'h0,    38'h0,   1'b0, 8'h00, 4'd0, 39'h0);
        // Negative stride, PC 0x800
        add(1'b1, 32'h800, 39'h2000, 38'h3, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h800, 39'h1F80, 38'h3, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h800, 39'h1F00, 38'h3, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h800, 39'h1E80, 38'h3, 1'b1, 8'hFE, 4'd2, 39'h1E00);
        add(1'b0, 32'h0,   39'h0,    38'h0, 1'b0, 8'h00, 4'd0, 39'h0);
        // Stride break, PC 0x404
        add(1'b1, 32'h404, 39'h5000, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h5040, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h5080, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h50C0, 38'h7, 1'b1, 8'h01, 4'd2, 39'h5100);
        add(1'b1, 32'h404, 39'h54C0, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h5500, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h5540, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h5580, 38'h8, 1'b1, 8'h01, 4'd2, 39'h55C0);
        // Alias: same index, other tag, reallocates
        add(1'b1, 32'h444, 39'h55C0, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h55C0, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h404, 39'h5600, 38'h7, 1'b0, 8'h00, 4'd0, 39'h0);
        // Largest legal stride (+127 lines), PC 0x408
        add(1'b1, 32'h408, 39'h10000, 38'h9, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h408, 39'h11FC0, 38'h9, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h408, 39'h13F80, 38'h9, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h408, 39'h15F40, 38'h9, 1'b1, 8'h7F, 4'd2, 39'h17F00);
        // Out-of-range stride (+128 lines) never trains, PC 0x40C
        add(1'b1, 32'h40C, 39'h0,    38'h1, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h40C, 39'h2000, 38'h1, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h40C, 39'h4000, 38'h1, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h40C, 39'h6000, 38'h1, 1'b0, 8'h00, 4'd0, 39'h0);
        // Target wraps at the top of the address space, PC 0x410
        add(1'b1, 32'h410, 39'h7FFFFFFEC0, 38'h2, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h410, 39'h7FFFFFFF00, 38'h2, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h410, 39'h7FFFFFFF40, 38'h2, 1'b0, 8'h00, 4'd0, 39'h0);
        add(1'b1, 32'h410, 39'h7FFFFFFF80, 38'h2, 1'b1, 8'h01, 4'd2, 39'h7FFFFFFFC0);
        add(1'b1, 32'h410, 39'h7FFFFFFFC0, 38'h2, 1'b1, 8'h01, 4'd3, 39'h0);
        add(1'b0, 32'h0,   39'h0,          38'h0, 1'b0, 8'h00, 4'd0, 39'h0);

        foreach (vt[i]) begin
            drive(vt[i].ldv, vt[i].pc, vt[i].la, vt[i].sp, 1'b0, 1'b0);
            check_op($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].ew, vt[i].ela, vt[i].sp);
        end

        // Backpressure: first op held, three later issues dropped
        train4(32'h414, 39'h1000, "bp_train");
        drive(1'b1, 32'h414, 39'h1100, 38'h66, 1'b0, 1'b1);
        check_op("bp_hold1", 1'b1, 8'h01, 4'd2, 39'h1100, 38'h55);
        drive(1'b1, 32'h414, 39'h1140, 38'h66, 1'b0, 1'b1);
        check_op("bp_hold2", 1'b1, 8'h01, 4'd2, 39'h1100, 38'h55);
        drive(1'b1, 32'h414, 39'h1180, 38'h66, 1'b0, 1'b1);
        check_op("bp_hold3", 1'b1, 8'h01, 4'd2, 39'h1100, 38'h55);
        drive(1'b0, 32'h0, 39'h0, 38'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 39'h0, 38'h0, 1'b0, 1'b1);
        check_op("bp_hold5", 1'b1, 8'h01, 4'd2, 39'h1100, 38'h55);
`ifdef PFGEN_STATS_EN
        check_drop("bp_drops", 16'd3);
`endif
        drive(1'b0, 32'h0, 39'h0, 38'h0, 1'b0, 1'b0);
        check_op("bp_release", 1'b0, 8'h00, 4'd0, 39'h0, 38'h0);
        drive(1'b0, 32'h0, 39'h0, 38'h0, 1'b0, 1'b0);
        check_op("bp_idle", 1'b0, 8'h00, 4'd0, 39'h0, 38'h0);

        // Flush with a same-cycle load; pending op survives, entry is gone
        train4(32'h418, 39'h3000, "fl_train");
        drive(1'b1, 32'h418, 39'h3100, 38'h77, 1'b1, 1'b1);
        check_op("fl_pending", 1'b1, 8'h01, 4'd2, 39'h3100, 38'h55);
`ifdef PFGEN_STATS_EN
        check_drop("fl_nodrop", 16'd3);
`endif
        drive(1'b0, 32'h0, 39'h0, 38'h0, 1'b0, 1'b0);
        check_op("fl_xfer", 1'b0, 8'h00, 4'd0, 39'h0, 38'h0);
        drive(1'b1, 32'h418, 39'h3140, 38'h77, 1'b0, 1'b0);
        check_op("fl_miss", 1'b0, 8'h00, 4'd0, 39'h0, 38'h0);
        drive(1'b1, 32'h418, 39'h3180, 38'h77, 1'b0, 1'b0);
        check_op("fl_retrain", 1'b0, 8'h00, 4'd0, 39'h0, 38'h0);

        // Asynchronous reset while an op is held
        train4(32'h41C, 39'h4000, "rst_train");
        op_retry = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_zero("rst_async");
`ifdef PFGEN_STATS_EN
        check_drop("rst_cnt", 16'd0);
`endif
        @(posedge clk);
        #3;
        reset = 1'b0;
        drive(1'b1, 32'h41C, 39'h4100, 38'h5, 1'b0, 1'b0);
        drive(1'b1, 32'h41C, 39'h4140, 38'h5, 1'b0, 1'b0);
        drive(1'b1, 32'h41C, 39'h4180, 38'h5, 1'b0, 1'b0);
        check_op("rst_3rd", 1'b0, 8'h00, 4'd0, 39'h0, 38'h0);
        drive(1'b1, 32'h41C, 39'h41C0, 38'h5, 1'b0, 1'b0);
        check_op("rst_4th", 1'b1, 8'h01, 4'd2, 39'h4200, 38'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pfgen_stride.md
Name: pfgen_stride

Overview:
PC-indexed stride prefetch generator sitting directly upstream of the prefetch engine.
- Observes demand load accesses (PC, linear address, sptbr) and trains a direct-mapped stride table.
- When an entry's stride is confident, emits one prefetch op {delta, weight, laddr, sptbr} on the pfgtopfe_op valid/retry interface.
- The op is held in a single output register until the prefetch engine accepts it.

Parameters:
ENTRIES, 16, stride table entries (power of 2); IDX_W = log2(ENTRIES)
TAG_W, 8, PC tag bits stored per entry
PC_W, 32, load PC width
LADDR_W, 39, linear address width (SC_laddr_type)
SPTBR_W, 38, page-table base width (SC_sptbr_type)
DELTA_W, 8, signed stride width in cache lines (PF_delta_type)
WEIGHT_W, 4, weight width (PF_weigth_type)
LINE_SHIFT, 6, log2 cache line bytes

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ld_valid  in  1  demand load observed this cycle (always accepted, no retry)
ld_pc  in  PC_W  load PC
ld_laddr  in  LADDR_W  load linear address
ld_sptbr  in  SPTBR_W  load page-table base
flush  in  1  invalidate all table entries
pfgtopfe_op_valid  out  1  prefetch op valid
pfgtopfe_op_retry  in  1  engine cannot accept; hold op
pfgtopfe_op_d  out  DELTA_W  signed stride in lines
pfgtopfe_op_w  out  WEIGHT_W  confidence, zero-extended
pfgtopfe_op_laddr  out  LADDR_W  prefetch target, line aligned
pfgtopfe_op_sptbr  out  SPTBR_W  copy of ld_sptbr

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- On reset:
  - All entries are invalid.
  - pfgtopfe_op_valid = 0.
  - d, w, laddr and sptbr outputs are all 0.
- Entry contents: valid, tag, last_line (LADDR_W-LINE_SHIFT bits), stride (signed DELTA_W), conf (2-bit saturating).
- Index and tag:
  - idx = ld_pc[IDX_W+1:2]
  - tag = ld_pc[IDX_W+2+TAG_W-1:IDX_W+2]
  - line = ld_laddr >> LINE_SHIFT
- Table update, one cycle after ld_valid:
  - Miss (invalid, or tag mismatch): allocate with tag, last_line = line, stride = 0, conf = 0. No issue.
  - Hit: compute delta = line - last_line, full width, signed.
    - If delta is within [-(2^(DELTA_W-1)-1), 2^(DELTA_W-1)-1], is nonzero, and equals stride: conf = min(conf+1, 3).
    - Otherwise: stride = delta if in range and nonzero, else 0; conf = 0.
    - last_line = line in all hit cases.
- Issue condition: hit AND updated conf >= 2 AND stride != 0. The issued op is:
  - d = stride
  - w = updated conf, zero-extended
  - laddr = ((line + sign-extended stride) << LINE_SHIFT), truncated to LADDR_W (wraps modulo 2^LADDR_W)
  - sptbr = ld_sptbr
- Latency: the op becomes visible on pfgtopfe_op_* in the cycle after the triggering ld_valid.
- Handshake:
  - A transfer occurs on a cycle where valid=1 and retry=0.
  - While valid=1 and retry=1, all op fields are held stable.
  - The output register loads a new op when valid=0, or when valid=1 and retry=0 (same-cycle replace; no bubble).
  - A new issue arriving while valid=1 and retry=1 is dropped. The table is still updated.
  - With no new issue, valid clears after a transfer.
- flush: all entries are invalidated next edge.
  - flush takes priority over a same-cycle ld_valid; that load is ignored.
  - A pending output op is not cancelled.
- Reset mid-operation: the output is cleared immediately (asynchronous) and any held op is discarded.

Optional Feature:
PFGEN_STATS_EN
- Defined: adds outputs pfgen_issue_cnt (16 bits) and pfgen_drop_cnt (16 bits).
  - pfgen_issue_cnt counts transfers; pfgen_drop_cnt counts dropped issues.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Positive stride: loads at PC 0x400 with laddr 0x1000, 0x1040, 0x1080, 0x10C0, retry=0 -> single op after the 4th load with d=0x01, w=2, laddr=0x1100; a 5th load at 0x1100 -> op d=0x01, w=3, laddr=0x1140.
- Negative stride: loads at PC 0x800 with laddr 0x2000, 0x1F80, 0x1F00, 0x1E80 -> op d=0xFE, w=2, laddr=0x1E00.
- Backpressure: train as in the positive-stride case, hold retry=1 for 5 cycles while 3 more trained loads issue -> fields stay at the first op (laddr 0x1100), later issues dropped (drop_cnt=3 with PFGEN_STATS_EN); drop retry -> exactly one transfer, then valid=0.
- Stride break and alias:
  - Trained entry then laddr jump of +0x400 -> conf=0, no op for the next 2 matching loads, op again on the 3rd.
  - PC 0x440 (same idx, different tag) -> reallocation, no op.
- Flush: after training, assert flush together with ld_valid -> next load at the same PC is a miss, no op; an already-pending op still transfers.
- Async reset: assert reset mid-cycle while valid=1, retry=1 -> valid falls without a clock edge; after release, the previously trained PC needs 4 loads to issue again.
